gauss_noise_sched: RTL

- Shares one Gaussian inverse-CDF model instance among N_REQ noise consumers.
- Owns a 31-bit LFSR that produces the uniform codes driven into the model's 31-bit `in_` port.
- Arbitrates requests round-robin, issues at most one code per cycle, and tags each issued code.
- Routes each model result back to the requester that was granted it, after the model's fixed pipeline latency.

---
 rtl/gauss_noise_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/gauss_noise_sched.sv
// gauss_noise_sched
//   Shares one Gaussian inverse-CDF model among N_REQ consumers. A 31-bit
//   Fibonacci LFSR (x^31+x^28+1) supplies uniform codes to the model. The
//   block grants one requester per cycle in round-robin order and tags each
//   issued code with the winner index. The model result comes back LAT cycles
//   later and is routed to that requester.
//
// Ports
//   clk        clock
//   rst        asynchronous active-low reset
//   req        level request per consumer, held until granted
//   gnt        registered one-hot grant pulse
//   cdf_in     uniform code driven to the model input
//   cdf_valid  cdf_in carries a new sample this cycle
//   cdf_out    model result, valid LAT cycles after cdf_valid
//   rsp_valid  registered one-hot result strobe
//   rsp_data   result for the requester flagged in rsp_valid
//   lfsr_load  load lfsr_seed into the LFSR (takes priority over a grant)
//   lfsr_seed  seed value for lfsr_load
//   busy       one or more samples are in flight
module gauss_noise_sched #(
  parameter int          N_REQ = 4,
  parameter int          LAT   = 2,
  parameter int          OUT_W = 16,
  parameter logic [30:0] SEED  = 31'h0000_0001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [30:0]      cdf_in,
  output logic             cdf_valid,
  input  logic [OUT_W-1:0] cdf_out,
  output logic [N_REQ-1:0] rsp_valid,
  output logic [OUT_W-1:0] rsp_data,
  input  logic             lfsr_load,
  input  logic [30:0]      lfsr_seed,
  output logic             busy
);

  localparam int          IDX_W     = $clog2(N_REQ);
  // A zero LFSR state would lock up, so zero seeds are replaced by 1.
  localparam logic [30:0] SEED_SAFE = (SEED == 31'd0) ? 31'd1 : SEED;

  logic [30:0]      lfsr_state;
  logic [30:0]      lfsr_next;
  logic [IDX_W-1:0] last_winner;
  logic [IDX_W-1:0] gnt_idx;      // index of the requester granted this cycle
  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  int               scan_idx;

  // Tag pipeline: stage k holds the sample issued k+1 cycles ago.
  logic [LAT-1:0]   tag_valid;
  logic [IDX_W-1:0] tag_idx [LAT];

  assign lfsr_next = {lfsr_state[29:0], lfsr_state[30] ^ lfsr_state[27]};

  // Round-robin search starting just above the previous winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      scan_idx = (int'(last_winner) + k) % N_REQ;
      if (!pick_found && req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(scan_idx);
      end
    end
  end

  // Issue side: LFSR, grant, code to the model.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_state  <= SEED_SAFE;
      last_winner <= IDX_W'(N_REQ - 1);
      gnt_idx     <= '0;
      gnt         <= '0;
      cdf_valid   <= 1'b0;
      cdf_in      <= '0;
    end else if (lfsr_load) begin
      // Requests stay pending; they are served on a later edge.
      lfsr_state <= (lfsr_seed == 31'd0) ? 31'd1 : lfsr_seed;
      gnt        <= '0;
      cdf_valid  <= 1'b0;
    end else if (pick_found) begin
      gnt         <= N_REQ'(1) << pick_idx;
      cdf_valid   <= 1'b1;
      cdf_in      <= lfsr_state;
      lfsr_state  <= lfsr_next;
      last_winner <= pick_idx;
      gnt_idx     <= pick_idx;
    end else begin
      gnt       <= '0;
      cdf_valid <= 1'b0;
    end
  end

  // First tag stage follows the issue registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_valid[0] <= 1'b0;
      tag_idx[0]   <= '0;
    end else begin
      tag_valid[0] <= cdf_valid;
      tag_idx[0]   <= gnt_idx;
    end
  end

  generate
    for (genvar gi = 1; gi < LAT; gi++) begin : g_tag
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          tag_valid[gi] <= 1'b0;
          tag_idx[gi]   <= '0;
        end else begin
          tag_valid[gi] <= tag_valid[gi-1];
          tag_idx[gi]   <= tag_idx[gi-1];
        end
      end
    end
  endgenerate

  // The last tag stage lines up with the cycle in which cdf_out is valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else if (tag_valid[LAT-1]) begin
      rsp_valid <= N_REQ'(1) << tag_idx[LAT-1];
      rsp_data  <= cdf_out;
    end else begin
      rsp_valid <= '0;
    end
  end

  assign busy = (|tag_valid) | (|rsp_valid);

endmodule
